// File: rtl/opb_simple_master.sv
`default_nettype none
// ============================================================================
// Module   : opb_simple_master
// Brief    : Single-beat OPB initiator bridging a command/response handshake
//            to an OPB master port (arbitration, ack, retry, error, timeout).
// Revision : 1.0
// ============================================================================
module opb_simple_master #(
  parameter int C_OPB_AWIDTH     = 32,
  parameter int C_OPB_DWIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 16,
  parameter int C_MAX_RETRY      = 4
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  // user command / response
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]   cmd_data,
  input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_OPB_DWIDTH-1:0]   rsp_data,
  output logic [1:0]                rsp_err,
  // OPB master port
  output logic                      M_request,
  output logic                      M_select,
  output logic                      M_RNW,
  output logic                      M_busLock,
  output logic                      M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1] M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  input  logic                      OPB_MGrant,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_toutSup,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);

  localparam int         c_be_w      = C_OPB_DWIDTH / 8;
  localparam logic [7:0] c_tout_last = 8'(C_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] c_max_retry = 4'(C_MAX_RETRY);
  localparam logic [1:0] c_err_ok    = 2'd0;
  localparam logic [1:0] c_err_ack   = 2'd1;
  localparam logic [1:0] c_err_tout  = 2'd2;
  localparam logic [1:0] c_err_retry = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_XFER       = 3'd2,
    S_RETRY_WAIT = 3'd3,
    S_RESP       = 3'd4
  } state_t;

  state_t                    r_state;
  logic                      r_rnw;
  logic [C_OPB_AWIDTH-1:0]   r_addr;
  logic [C_OPB_DWIDTH-1:0]   r_data;
  logic [c_be_w-1:0]         r_be;
  logic [7:0]                r_tout_cnt;
  logic [3:0]                r_retry_cnt;

  logic [3:0]                w_retry_inc;
  logic                      w_retry_hit;
  logic                      w_to_wait;
  logic                      w_finish;
  logic [1:0]                w_err;
  logic [C_OPB_DWIDTH-1:0]   w_rdata;

  assign M_busLock = 1'b0;
  assign M_seqAddr = 1'b0;

  // Outcome of the current XFER cycle, resolved in bus-response priority order.
  always_comb begin
    w_retry_inc = r_retry_cnt + 4'd1;
    w_retry_hit = 1'b0;
    w_to_wait   = 1'b0;
    w_finish    = 1'b0;
    w_err       = c_err_ok;
    w_rdata     = '0;
    if (r_state == S_XFER) begin
      if (OPB_errAck) begin
        w_finish = 1'b1;
        w_err    = c_err_ack;
      end else if (OPB_xferAck) begin
        w_finish = 1'b1;
        if (r_rnw) w_rdata = OPB_DBus;
      end else if (OPB_retry) begin
        w_retry_hit = 1'b1;
        if (w_retry_inc == c_max_retry) begin
          w_finish = 1'b1;
          w_err    = c_err_retry;
        end else begin
          w_to_wait = 1'b1;
        end
      end else if (r_tout_cnt == c_tout_last) begin
        w_finish = 1'b1;
        w_err    = c_err_tout;
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      r_state     <= S_IDLE;
      r_rnw       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_be        <= '0;
      r_tout_cnt  <= '0;
      r_retry_cnt <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= c_err_ok;
      M_request   <= 1'b0;
      M_select    <= 1'b0;
      M_RNW       <= 1'b0;
      M_ABus      <= '0;
      M_BE        <= '0;
      M_DBus      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_retry_cnt <= '0;
          if (cmd_valid && cmd_ready) begin
            r_rnw     <= cmd_rnw;
            r_addr    <= cmd_addr;
            r_data    <= cmd_data;
            r_be      <= cmd_be;
            cmd_ready <= 1'b0;
            M_request <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_REQ: begin
          if (OPB_MGrant) begin
            M_request  <= 1'b0;
            M_select   <= 1'b1;
            M_RNW      <= r_rnw;
            M_ABus     <= r_addr;
            M_BE       <= r_be;
            M_DBus     <= r_rnw ? '0 : r_data;
            r_tout_cnt <= '0;
            r_state    <= S_XFER;
          end
        end

        S_XFER: begin
          if (!OPB_toutSup) r_tout_cnt <= r_tout_cnt + 8'd1;
          if (w_retry_hit) r_retry_cnt <= w_retry_inc;
          // Address/data buses must return to zero whenever select drops.
          if (w_finish || w_to_wait) begin
            M_select <= 1'b0;
            M_RNW    <= 1'b0;
            M_ABus   <= '0;
            M_BE     <= '0;
            M_DBus   <= '0;
          end
          if (w_finish) begin
            rsp_valid <= 1'b1;
            rsp_data  <= w_rdata;
            rsp_err   <= w_err;
            r_state   <= S_RESP;
          end else if (w_to_wait) begin
            r_state <= S_RETRY_WAIT;
          end
        end

        S_RETRY_WAIT: begin
          M_request <= 1'b1;
          r_state   <= S_REQ;
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= c_err_ok;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opb_simple_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_simple_master
// Brief    : Self-checking bench for opb_simple_master (directed + random).
// Revision : 1.0
// ============================================================================
module tb_opb_simple_master;

  localparam int TOUT = 16;
  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_ready = 1'b1;
  logic        mgrant = 1'b0, xack = 1'b0, eack = 1'b0, retry = 1'b0, tsup = 1'b0;
  logic [0:31] opb_dbus = '0;

  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        M_request, M_select, M_RNW, M_busLock, M_seqAddr;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;

  always #5 clk = ~clk;

  opb_simple_master #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_TIMEOUT_CYCLES(TOUT), .C_MAX_RETRY(MAXR)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW),
    .M_busLock(M_busLock), .M_seqAddr(M_seqAddr),
    .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .OPB_MGrant(mgrant), .OPB_xferAck(xack), .OPB_errAck(eack),
    .OPB_retry(retry), .OPB_toutSup(tsup), .OPB_DBus(opb_dbus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction-walking thread) ----------
  logic        e_cmd_ready, e_request, e_select, e_rnw, e_rsp_valid;
  logic [31:0] e_abus, e_dbus, e_rsp_data;
  logic [3:0]  e_be;
  logic [1:0]  e_rsp_err;

  task automatic clear_bus();
    e_request = 1'b0; e_select = 1'b0; e_rnw = 1'b0;
    e_abus = '0; e_be = '0; e_dbus = '0;
  endtask

  task automatic tick(output bit ab);
    @(posedge clk);
    ab = (rst_n !== 1'b1);
  endtask

  task automatic model_run(output bit ab);
    logic        rnw;
    logic [31:0] addr, data;
    logic [3:0]  be;
    int          retries, cnt;
    bit          done;
    tick(ab); if (ab) return;
    forever begin
      e_cmd_ready = 1'b1;
      do begin tick(ab); if (ab) return; end while (cmd_valid !== 1'b1);
      rnw = cmd_rnw; addr = cmd_addr; data = cmd_data; be = cmd_be;
      e_cmd_ready = 1'b0;
      retries = 0;
      done = 1'b0;
      while (!done) begin
        e_request = 1'b1;
        do begin tick(ab); if (ab) return; end while (mgrant !== 1'b1);
        e_request = 1'b0; e_select = 1'b1; e_rnw = rnw;
        e_abus = addr; e_be = be; e_dbus = rnw ? 32'h0 : data;
        cnt = 0;
        forever begin
          tick(ab); if (ab) return;
          if (eack) begin
            e_rsp_err = 2'd1; e_rsp_data = 32'h0; done = 1'b1; break;
          end else if (xack) begin
            e_rsp_err = 2'd0; e_rsp_data = rnw ? 32'(opb_dbus) : 32'h0; done = 1'b1; break;
          end else if (retry) begin
            retries++;
            if (retries == MAXR) begin
              e_rsp_err = 2'd3; e_rsp_data = 32'h0; done = 1'b1;
            end
            break;
          end else if (cnt == TOUT - 1) begin
            e_rsp_err = 2'd2; e_rsp_data = 32'h0; done = 1'b1; break;
          end
          if (!tsup) cnt++;
        end
        clear_bus();
        if (!done) begin tick(ab); if (ab) return; end
      end
      e_rsp_valid = 1'b1;
      do begin tick(ab); if (ab) return; end while (rsp_ready !== 1'b1);
      e_rsp_valid = 1'b0; e_rsp_data = '0; e_rsp_err = '0;
    end
  endtask

  initial begin : model
    bit ab;
    forever begin
      clear_bus();
      e_cmd_ready = 1'b0; e_rsp_valid = 1'b0; e_rsp_data = '0; e_rsp_err = '0;
      wait (rst_n === 1'b1);
      model_run(ab);
    end
  end

  // ---------------- compare process ----------------------------------------
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      check1("rst_cmd_ready", cmd_ready, 1'b0);
      check1("rst_request", M_request, 1'b0);
      check1("rst_select", M_select, 1'b0);
      check32("rst_abus", M_ABus, 32'h0);
      check32("rst_dbus", M_DBus, 32'h0);
      check1("rst_rsp_valid", rsp_valid, 1'b0);
    end else begin
      check1("cmd_ready", cmd_ready, e_cmd_ready);
      check1("M_request", M_request, e_request);
      check1("M_select", M_select, e_select);
      check1("M_RNW", M_RNW, e_rnw);
      check32("M_ABus", M_ABus, e_abus);
      check32("M_BE", 32'(M_BE), 32'(e_be));
      check32("M_DBus", M_DBus, e_dbus);
      check1("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        check32("rsp_data", rsp_data, e_rsp_data);
        check32("rsp_err", 32'(rsp_err), 32'(e_rsp_err));
      end
    end
    check1("M_busLock", M_busLock, 1'b0);
    check1("M_seqAddr", M_seqAddr, 1'b0);
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin step(); n++; end
    check1(nm, cmd_ready, 1'b1);
  endtask

  // Returns in cycle 1 (one edge after the accepting edge).
  task automatic send_cmd(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wait_ready("cmd_ready_before_send");
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_data = d; cmd_be = be;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic retry_test(input int nret, input string nm, input int exp_bursts, input int exp_err);
    int bursts = 0;
    int n = 0;
    logic prev = 1'b0;
    mgrant = 1'b1;
    send_cmd(1'b0, $urandom, $urandom, 4'hF);
    while (rsp_valid !== 1'b1 && n < 100) begin
      retry = 1'b0; xack = 1'b0;
      if (M_select === 1'b1 && !prev) begin
        bursts++;
        if (bursts <= nret) retry = 1'b1; else xack = 1'b1;
      end
      prev = M_select;
      step(); n++;
    end
    retry = 1'b0; xack = 1'b0;
    check1({nm, "_rsp_valid"}, rsp_valid, 1'b1);
    check32({nm, "_bursts"}, bursts, exp_bursts);
    check32({nm, "_err"}, 32'(rsp_err), exp_err);
    step();
  endtask

  task automatic tout_test(input int sup_cycles, input string nm, input int exp_lat);
    int n = 0;
    int s = -1;
    int sup_left = 0;
    mgrant = 1'b1;
    send_cmd(1'b1, 32'h01208110, 32'h0, 4'hF);
    while (rsp_valid !== 1'b1 && n < 200) begin
      if (M_select === 1'b1 && s < 0) begin s = n; sup_left = sup_cycles; end
      tsup = (sup_left > 0);
      if (sup_left > 0) sup_left--;
      step(); n++;
    end
    tsup = 1'b0;
    check32({nm, "_latency"}, n - s, exp_lat);
    check32({nm, "_err"}, 32'(rsp_err), 32'd2);
    check32({nm, "_data"}, rsp_data, 32'h0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence -------------------------------------------
  initial begin
    int nreq;
    int p_ack, p_err, p_retry, p_sup, p_grant;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check1("reset_cmd_ready_first_clock", cmd_ready, 1'b1);

    // write, immediate grant, ack one cycle after select
    mgrant = 1'b1; rsp_ready = 1'b1;
    send_cmd(1'b0, 32'h01208100, 32'hDEADBEEF, 4'hF);
    check1("t1_request_c1", M_request, 1'b1);
    step();
    check1("t1_select_c2", M_select, 1'b1);
    check32("t1_abus", M_ABus, 32'h01208100);
    check32("t1_dbus", M_DBus, 32'hDEADBEEF);
    check1("t1_rnw", M_RNW, 1'b0);
    check32("t1_model_abus", e_abus, 32'h01208100);
    step();
    xack = 1'b1;
    step();
    xack = 1'b0;
    check1("t1_rsp_valid_c4", rsp_valid, 1'b1);
    check32("t1_rsp_err", 32'(rsp_err), 32'd0);
    check32("t1_rsp_data", rsp_data, 32'h0);
    check1("t1_select_dropped", M_select, 1'b0);
    step();

    // read with grant delayed 5 cycles
    mgrant = 1'b0;
    send_cmd(1'b1, 32'h01208104, 32'h5555AAAA, 4'hF);
    nreq = 0;
    for (int i = 1; i <= 5; i++) begin
      if (M_request === 1'b1) nreq++;
      check32("t2_dbus_during_req", M_DBus, 32'h0);
      if (i == 5) mgrant = 1'b1;
      step();
    end
    check32("t2_request_cycles", nreq, 5);
    check1("t2_select", M_select, 1'b1);
    check1("t2_rnw", M_RNW, 1'b1);
    check32("t2_dbus_read", M_DBus, 32'h0);
    xack = 1'b1; opb_dbus = 32'h12345678;
    step();
    xack = 1'b0; opb_dbus = '0;
    check1("t2_rsp_valid", rsp_valid, 1'b1);
    check32("t2_rsp_data", rsp_data, 32'h12345678);
    check32("t2_model_rsp_data", e_rsp_data, 32'h12345678);
    check32("t2_rsp_err", 32'(rsp_err), 32'd0);
    step();

    retry_test(2, "t3_retry2", 3, 0);
    retry_test(4, "t3_retry4", 4, 3);

    tout_test(0, "t4_timeout", 16);
    tout_test(10, "t4_timeout_sup", 26);

    // simultaneous errAck and xferAck
    mgrant = 1'b1;
    send_cmd(1'b1, 32'h01208108, 32'h0, 4'hF);
    step();
    eack = 1'b1; xack = 1'b1; opb_dbus = 32'hFFFFFFFF;
    step();
    eack = 1'b0; xack = 1'b0; opb_dbus = '0;
    check1("t5_rsp_valid", rsp_valid, 1'b1);
    check32("t5_rsp_err", 32'(rsp_err), 32'd1);
    check32("t5_rsp_data", rsp_data, 32'h0);
    step();

    // back-pressured response
    rsp_ready = 1'b0;
    send_cmd(1'b1, 32'h0120810C, 32'h0, 4'h3);
    step();
    xack = 1'b1; opb_dbus = 32'hA5A50F0F;
    step();
    xack = 1'b0; opb_dbus = '0;
    for (int i = 0; i < 7; i++) begin
      check1("t6_rsp_valid_hold", rsp_valid, 1'b1);
      check32("t6_rsp_data_hold", rsp_data, 32'hA5A50F0F);
      check1("t6_cmd_ready_low", cmd_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    check1("t6_rsp_valid_before_accept", rsp_valid, 1'b1);
    step();
    check1("t6_rsp_valid_after_accept", rsp_valid, 1'b0);
    check1("t6_cmd_ready_after_accept", cmd_ready, 1'b1);

    // reset mid-XFER
    send_cmd(1'b0, 32'h01208114, 32'hCAFEF00D, 4'hF);
    step();
    check1("t7_select_before_reset", M_select, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check1("t7_select_async_clear", M_select, 1'b0);
    check32("t7_abus_async_clear", M_ABus, 32'h0);
    step();
    #1 rst_n = 1'b1;
    step();
    check1("t7_cmd_ready_after_release", cmd_ready, 1'b1);
    check1("t7_no_rsp", rsp_valid, 1'b0);

    // randomized traffic
    p_ack = 30; p_err = 5; p_retry = 10; p_sup = 10; p_grant = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        p_ack   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 60));
        p_err   = int'($urandom_range(0, 10));
        p_retry = int'($urandom_range(0, 30));
        p_sup   = int'($urandom_range(0, 40));
        p_grant = int'($urandom_range(20, 100));
      end
      cmd_valid = ($urandom_range(0, 99) < 60);
      cmd_rnw   = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_data  = $urandom;
      cmd_be    = 4'($urandom);
      rsp_ready = ($urandom_range(0, 99) < 70);
      mgrant    = ($urandom_range(0, 99) < p_grant);
      xack      = ($urandom_range(0, 99) < p_ack);
      eack      = ($urandom_range(0, 99) < p_err);
      retry     = ($urandom_range(0, 99) < p_retry);
      tsup      = ($urandom_range(0, 99) < p_sup);
      opb_dbus  = $urandom;
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        step();
        #1 rst_n = 1'b1;
      end
      step();
    end

    cmd_valid = 1'b0; rsp_ready = 1'b1; mgrant = 1'b1;
    xack = 1'b1; eack = 1'b0; retry = 1'b0; tsup = 1'b0;
    repeat (40) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opb_simple_master.md
# opb_simple_master

Single-beat OPB initiator that lets fabric logic issue 32-bit register reads and writes to OPB slaves such as the ppc2simulink/simulink2ppc software registers. The block sits between a user-side command/response handshake and the OPB master port, and runs entirely in the OPB clock domain. It handles bus arbitration, slave acknowledge, retry, error and timeout, and returns one response per accepted command.

## Interface
- C_OPB_AWIDTH, 32, OPB address width (fixed at 32).
- C_OPB_DWIDTH, 32, OPB data width (fixed at 32).
- C_TIMEOUT_CYCLES, 16, XFER cycles without an acknowledge before a timeout response; valid range 2–255.
- C_MAX_RETRY, 4, OPB_retry events tolerated per command before giving up; valid range 1–15.
- OPB_Clk  in  1  sole clock.
- OPB_Rst  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1 each  command handshake.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  32  byte address.
- cmd_data  in  32  write data.
- cmd_be  in  4  byte enables.
- rsp_valid / rsp_ready  out / in  1 each  response handshake.
- rsp_data  out  32  read data; 0 for writes.
- rsp_err  out  2  0 = OK, 1 = errAck, 2 = timeout, 3 = retries exhausted.
- M_request  out  1  bus request.
- M_select  out  1  transfer valid.
- M_RNW  out  1  read/write direction on the bus.
- M_busLock, M_seqAddr  out  1 each  tied 0.
- M_ABus  out  [0:31]  address bus.
- M_BE  out  [0:3]  byte enables on the bus.
- M_DBus  out  [0:31]  write data bus.
- OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup  in  1 each  bus responses.
- OPB_DBus  in  [0:31]  read data bus.

## Operation
- Bit mapping: cmd_addr[31] → M_ABus[0] … cmd_addr[0] → M_ABus[31]. The same MSB-to-MSB mapping applies to data and byte enables.
- OR-bus rule: while M_select = 0, drive M_ABus, M_BE and M_DBus to 0. During reads, M_DBus stays 0.
- States: IDLE, REQ, XFER, RETRY_WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_* and go to REQ.
  - Clear the retry counter.
- REQ:
  - M_request = 1.
  - When OPB_MGrant is sampled 1, go to XFER.
  - Wait indefinitely for the grant.
- XFER:
  - M_select = 1, with address, BE, RNW and write data driven; M_request = 0.
  - The timeout counter starts at 0 on entry and increments each cycle while OPB_toutSup = 0. It holds while OPB_toutSup = 1.
  - Per-cycle priority, highest first:
    1. errAck → RESP, err 1.
    2. xferAck → RESP, err 0; capture OPB_DBus if reading.
    3. retry → increment the retry counter. If it now equals C_MAX_RETRY, go to RESP with err 3; otherwise go to RETRY_WAIT.
    4. counter = C_TIMEOUT_CYCLES−1 → RESP, err 2.
  - M_select drops on the edge that leaves XFER.
- RETRY_WAIT: one idle cycle with all M_* outputs 0, then REQ.
- RESP:
  - rsp_valid = 1, with rsp_data and rsp_err held stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready = 0 throughout.
- rsp_data is 0 for every non-OK result and for all writes.
- Reset mid-operation: all M_* outputs clear asynchronously and the in-flight command is dropped with no response.

## Timing
- Reset values: all outputs 0, state IDLE. cmd_ready rises in the first clock after reset deasserts.
- Cycle numbering, with the command accepted at edge 0:
  - M_request = 1 in cycle 1.
  - If OPB_MGrant = 1 in cycle 1, M_select = 1 in cycle 2.
  - If xferAck arrives in cycle n (n ≥ 2), rsp_valid = 1 in cycle n+1 and M_select = 0 in cycle n+1.
- Minimum command-to-response latency is 3 cycles. With rsp_ready held at 1, cmd_ready returns the cycle after the response handshake, giving a minimum of 4 cycles per transaction.
- The response handshake completes only on a cycle where rsp_valid & rsp_ready are both 1. rsp_* are registered outputs.

## Test plan
- Write, immediate grant, slave acks 1 cycle after select:
  - Stimulus: addr 0x01208100, data 0xDEADBEEF, be 0xF, grant immediate.
  - Required response: M_ABus = 0x01208100, M_DBus = 0xDEADBEEF and M_RNW = 0 while M_select = 1. rsp_err = 0, rsp_data = 0, rsp_valid in cycle 4.
- Read with grant delayed:
  - Stimulus: read of 0x01208104; grant delayed 5 cycles; slave returns 0x12345678 with xferAck.
  - Required response: M_request held for 5 cycles, M_DBus = 0 throughout, rsp_data = 0x12345678, rsp_err = 0.
- Retry then success:
  - Stimulus: slave asserts OPB_retry twice, then xferAck.
  - Required response: two RETRY_WAIT gaps, three M_select bursts, rsp_err = 0.
  - Repeat with 4 retries: required response is rsp_err = 3 after the 4th select burst.
- Timeout with suppression:
  - Stimulus: no acknowledge.
  - Required response: rsp_err = 2 exactly 16 cycles after M_select rises.
  - Repeat with OPB_toutSup high for 10 cycles: the timeout is delayed by 10 cycles.
- Simultaneous errAck and xferAck:
  - Stimulus: OPB_errAck and OPB_xferAck in the same cycle, with OPB_DBus = 0xFFFFFFFF.
  - Required response: rsp_err = 1, rsp_data = 0.
- Reset mid-XFER, back-pressured response:
  - Stimulus: OPB_Rst pulsed low while M_select = 1.
  - Required response: M_select = 0 within the same cycle, no rsp_valid, cmd_ready = 1 after release.
  - With rsp_ready held 0 for 7 cycles, rsp_valid and rsp_data stay stable until accepted.
